// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller modes: normal flow, frozen on a slow memory access, dead on timeout.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    // E-stage operand mux selects.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // R15 is the PC; it is never produced by a forwarded ALU result.
    localparam logic [3:0] REG_PC = 4'd15;

    // True when a writing stage targets the given source register (PC excluded).
    function automatic logic src_hit(input logic       we,
                                     input logic [3:0] wa,
                                     input logic [3:0] ra);
        return we && (wa == ra) && (ra != REG_PC);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding comparator for one E-stage operand; the M result
// shadows the older W result when both target the same register.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] ra,
    input  logic       reg_write_m,
    input  logic [3:0] wa_m,
    input  logic       reg_write_w,
    input  logic [3:0] wa_w,
    output logic [1:0] sel
);

    // Priority encode M over W, register file otherwise.
    always_comb begin
        // NOTE: default assigned first so no path through the block can infer a latch.
        sel = FWD_RF;
        if (src_hit(reg_write_m, wa_m, ra)) begin
            sel = FWD_M;
        end else if (src_hit(reg_write_w, wa_w, ra)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control for the 5-stage F/D/E/M/W pipe,
// with PC-redirect tracking and a memory-timeout bus fault.
// Build option: define HAZ_FWD_EN to enable E-stage operand forwarding; without
// it forwarding is off and any in-flight writer of a D source stalls the pipe.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int PC_DEPTH = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       BusFault
);

    localparam int PC_W = (PC_DEPTH > 1) ? $clog2(PC_DEPTH) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state, state_next;
    logic [PC_W-1:0] pc_cnt, pc_next;
    logic [TO_W-1:0] to_cnt, to_next;
    logic [1:0]      fwd_a, fwd_b;
    logic            data_stall;
    logic            pc_pend;

`ifdef HAZ_FWD_EN
    fwd_sel u_fwd_a (
        .ra          (RA1E),
        .reg_write_m (RegWriteM),
        .wa_m        (WA3M),
        .reg_write_w (RegWriteW),
        .wa_w        (WA3W),
        .sel         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .ra          (RA2E),
        .reg_write_m (RegWriteM),
        .wa_m        (WA3M),
        .reg_write_w (RegWriteW),
        .wa_w        (WA3W),
        .sel         (fwd_b)
    );

    // Only a load in E cannot be forwarded in time; one bubble resolves it.
    assign data_stall = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    // No bypass paths: any pending writer of a D-stage source must drain first.
    assign data_stall = src_hit(RegWriteE, WA3E, RA1D) || src_hit(RegWriteE, WA3E, RA2D) ||
                        src_hit(RegWriteM, WA3M, RA1D) || src_hit(RegWriteM, WA3M, RA2D) ||
                        src_hit(RegWriteW, WA3W, RA1D) || src_hit(RegWriteW, WA3W, RA2D);

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{RA1E, RA2E, MemtoRegE};
`endif

    // A PC write is in flight from its D cycle until it retires PC_DEPTH cycles later.
    assign pc_pend = PCSrcD || (pc_cnt != '0);

    // Mode transitions, counter updates and the stall/flush/forward outputs.
    always_comb begin
        state_next = state;
        pc_next    = pc_cnt;
        to_next    = to_cnt;
        ForwardAE  = fwd_a;
        ForwardBE  = fwd_b;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        BusFault   = 1'b0;

        case (state)
            RUN: begin
                StallF = data_stall | pc_pend;
                StallD = data_stall;
                FlushD = pc_pend | BranchTakenE;
                FlushE = data_stall | BranchTakenE;
                if (MemReqM && !MemReadyM) begin
                    state_next = MEMWAIT;
                    to_next    = TO_W'(1);
                end
            end
            MEMWAIT: begin
                // Whole pipe frozen; W gets a bubble so no result retires twice.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                if (MemReadyM) begin
                    state_next = RUN;
                    to_next    = '0;
                end else if (to_cnt == TO_W'(TIMEOUT)) begin
                    state_next = FAULT;
                end else begin
                    to_next = to_cnt + TO_W'(1);
                end
            end
            FAULT: begin
                StallF   = 1'b1;
                StallD   = 1'b1;
                StallE   = 1'b1;
                StallM   = 1'b1;
                FlushW   = 1'b1;
                BusFault = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // A new redirect restarts the window; the window only drains while M moves.
        if (PCSrcD && !StallD) begin
            pc_next = PC_W'(PC_DEPTH - 1);
        end else if ((pc_cnt != '0) && !StallM) begin
            pc_next = pc_cnt - PC_W'(1);
        end

        // Reset empties every stage and holds nothing.
        if (!RESET_N) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            BusFault  = 1'b0;
        end
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking updates so every register sees pre-edge values.
        if (!RESET_N) begin
            state  <= RUN;
            pc_cnt <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            pc_cnt <= pc_next;
            to_cnt <= to_next;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the hazard controller.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT  = 16;
    localparam int PC_DEPTH = 3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, BranchTakenE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, BusFault;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 = flowing, 1 = waiting on memory, 2 = faulted.
    int m_mode = 0;
    int m_pend = 0;   // redirect cycles still owed after the current one
    int m_wait = 0;   // low-ready cycles seen in the current wait

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(
        .TIMEOUT  (TIMEOUT),
        .PC_DEPTH (PC_DEPTH)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .BusFault     (BusFault)
    );

    // Bit order: {FA[1:0], FB[1:0], SF, SD, SE, SM, FD, FE, FW, BF}
    function automatic logic [11:0] outs_now();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, BusFault};
    endfunction

`ifdef HAZ_FWD_EN
    function automatic logic [1:0] fwd_ref(input logic [3:0] src);
        if (src == 4'd15) return 2'b00;
        if (RegWriteM && WA3M == src) return 2'b10;
        if (RegWriteW && WA3W == src) return 2'b01;
        return 2'b00;
    endfunction
`endif

    // Expected outputs and compare mask for the current inputs and model state.
    function automatic void model_eval(output logic [11:0] e, output logic [11:0] m);
        logic [1:0] fa, fb;
        logic       hz, pend;
        logic [3:0] wa [3];
        logic       we [3];
        fa = 2'b00;
        fb = 2'b00;
        hz = 1'b0;
        wa = '{WA3E, WA3M, WA3W};
        we = '{RegWriteE, RegWriteM, RegWriteW};
`ifdef HAZ_FWD_EN
        fa = fwd_ref(RA1E);
        fb = fwd_ref(RA2E);
        hz = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
`else
        for (int k = 0; k < 3; k++) begin
            if (we[k] && ((wa[k] == RA1D && RA1D != 4'd15) || (wa[k] == RA2D && RA2D != 4'd15)))
                hz = 1'b1;
        end
`endif
        pend = PCSrcD || (m_pend > 0);
        m = 12'hFFF;
        if (!RESET_N) begin
            e = 12'b00_00_0000_111_0;
        end else if (m_mode == 0) begin
            e = {fa, fb, hz | pend, hz, 1'b0, 1'b0, pend | BranchTakenE, hz | BranchTakenE, 1'b0, 1'b0};
        end else if (m_mode == 1) begin
            e = {fa, fb, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0};
        end else begin
            e = {fa, fb, 4'b1111, 3'b000, 1'b1};
            m = 12'b1111_1111_0001;
        end
    endfunction

    // Advance the model by one clock, then move to just after the next edge.
    task automatic tick();
        logic [11:0] e, m;
        model_eval(e, m);
        if (!RESET_N) begin
            m_mode = 0;
            m_pend = 0;
            m_wait = 0;
        end else begin
            if (PCSrcD && !e[6]) m_pend = PC_DEPTH - 1;
            else if (m_pend > 0 && !e[4]) m_pend = m_pend - 1;
            if (m_mode == 0) begin
                if (MemReqM && !MemReadyM) begin
                    m_mode = 1;
                    m_wait = 1;
                end
            end else if (m_mode == 1) begin
                if (MemReadyM) begin
                    m_mode = 0;
                    m_wait = 0;
                end else if (m_wait == TIMEOUT) begin
                    m_mode = 2;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET_N = 1'b1;
        {RA1D, RA2D, RA1E, RA2E} = {4'd14, 4'd13, 4'd12, 4'd11};
        {WA3E, WA3M, WA3W} = {4'd0, 4'd0, 4'd0};
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = 4'b0000;
        {PCSrcD, BranchTakenE, MemReqM} = 3'b000;
        MemReadyM = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] e, m, got;
        for (int i = 0; i < 3; i++) begin
            RESET_N = 1'b0;
            RA1D = 4'($urandom); RA2D = 4'($urandom); RA1E = 4'($urandom); RA2E = 4'($urandom);
            WA3E = RA1D; WA3M = RA1E; WA3W = RA2E;
            {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = 4'b1111;
            PCSrcD = 1'b1; BranchTakenE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL reset[%0d] got=%b want=%b", i, got & m, e & m);
            end
            total++;
            if ({FlushD, FlushE, FlushW, BusFault} !== 4'b1110) begin
                bad++;
                $display("FAIL reset_flush[%0d] got=%b want=1110", i, {FlushD, FlushE, FlushW, BusFault});
            end
            tick();
        end
    endtask

    typedef struct {
        logic [3:0] ra1e, ra2e;
        logic       rwm;
        logic [3:0] wa3m;
        logic       rww;
        logic [3:0] wa3w;
        logic [1:0] fa, fb;
    } fwd_vec_t;

    task automatic test_forwarding();
        logic [11:0] e, m, got;
        logic [1:0]  wa_exp, wb_exp;
        fwd_vec_t tbl [6];
        tbl[0] = '{4'd1,  4'd3,  1'b1, 4'd1,  1'b1, 4'd1,  2'b10, 2'b00};
        tbl[1] = '{4'd5,  4'd15, 1'b1, 4'd15, 1'b0, 4'd0,  2'b00, 2'b00};
        tbl[2] = '{4'd4,  4'd4,  1'b0, 4'd4,  1'b1, 4'd4,  2'b01, 2'b01};
        tbl[3] = '{4'd2,  4'd7,  1'b1, 4'd7,  1'b1, 4'd2,  2'b01, 2'b10};
        tbl[4] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b1, 4'd15, 2'b00, 2'b00};
        tbl[5] = '{4'd6,  4'd6,  1'b0, 4'd6,  1'b0, 4'd6,  2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            idle();
            RA1E = tbl[i].ra1e; RA2E = tbl[i].ra2e;
            RegWriteM = tbl[i].rwm; WA3M = tbl[i].wa3m;
            RegWriteW = tbl[i].rww; WA3W = tbl[i].wa3w;
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL fwd[%0d] got=%b want=%b", i, got & m, e & m);
            end
`ifdef HAZ_FWD_EN
            wa_exp = tbl[i].fa;
            wb_exp = tbl[i].fb;
`else
            wa_exp = 2'b00;
            wb_exp = 2'b00;
`endif
            total++;
            if ({ForwardAE, ForwardBE} !== {wa_exp, wb_exp}) begin
                bad++;
                $display("FAIL fwd_sel[%0d] got=%b want=%b", i, {ForwardAE, ForwardBE}, {wa_exp, wb_exp});
            end
            tick();
        end
    endtask

    task automatic test_data_stall();
        logic [11:0] e, m, got;
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2; RA1D = 4'd2; RA2D = 4'd9; end
                1: begin RA1D = 4'd2; end
                2: begin MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd7; RA1D = 4'd3; RA2D = 4'd7; end
                3: begin RA2D = 4'd7; end
                default: begin MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA1D = 4'd6; RA2D = 4'd8; end
            endcase
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL ldstall[%0d] got=%b want=%b", i, got & m, e & m);
            end
            if (StallD) n++;
            tick();
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL ldstall_cycles got=%0d want=2", n);
        end
    endtask

    task automatic test_pc_redirect();
        logic [11:0] e, m, got;
        int n = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            PCSrcD = (i == 0);
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL pc[%0d] got=%b want=%b", i, got & m, e & m);
            end
            if (StallF) n++;
            tick();
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL pc_window got=%0d want=3", n);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            PCSrcD    = (i == 0);
            MemReqM   = (i >= 1 && i <= 3);
            MemReadyM = !(i == 1 || i == 2);
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL pc_wait[%0d] got=%b want=%b", i, got & m, e & m);
            end
            if (StallF) n++;
            tick();
        end
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL pc_wait_window got=%0d want=5", n);
        end
    endtask

    task automatic test_mem_wait();
        logic [11:0] e, m, got;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            MemReqM   = (i <= 4);
            MemReadyM = (i >= 4);
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL memwait[%0d] got=%b want=%b", i, got & m, e & m);
            end
            if ({StallF, StallD, StallE, StallM, FlushW} === 5'b11111) n++;
            total++;
            if (BusFault !== 1'b0) begin
                bad++;
                $display("FAIL memwait_fault[%0d] got=%b want=0", i, BusFault);
            end
            tick();
        end
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL memwait_cycles got=%0d want=4", n);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e, m, got;
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd3; RA1D = 4'd3; BranchTakenE = 1; end
                1: begin BranchTakenE = 1; end
                2: begin MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd4; RA2D = 4'd4; end
                default: ;
            endcase
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL b2b[%0d] got=%b want=%b", i, got & m, e & m);
            end
            if (i == 0) begin
                total++;
                if ({StallF, StallD, FlushD, FlushE} !== 4'b1111) begin
                    bad++;
                    $display("FAIL branch_ld got=%b want=1111", {StallF, StallD, FlushD, FlushE});
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [11:0] e, m, got;
        for (int i = 0; i < 23; i++) begin
            idle();
            MemReqM   = (i < 20);
            MemReadyM = (i >= 17);
            RESET_N   = (i != 20);
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, got & m, e & m);
            end
            total++;
            if (BusFault !== ((i >= 17 && i < 20) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL busfault[%0d] got=%b want=%b", i, BusFault, (i >= 17 && i < 20));
            end
            tick();
        end
        total++;
        if ({StallF, FlushD, FlushE, FlushW, BusFault} !== 5'b00000) begin
            bad++;
            $display("FAIL post_reset got=%b want=00000", {StallF, FlushD, FlushE, FlushW, BusFault});
        end
    endtask

    function automatic logic [3:0] pick_reg();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [11:0] e, m, got;
        for (int i = 0; i < 500; i++) begin
            RESET_N      = ($urandom_range(0, 39) != 0);
            RA1D = pick_reg(); RA2D = pick_reg(); RA1E = pick_reg(); RA2E = pick_reg();
            WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg();
            RegWriteE    = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = ($urandom_range(0, 2) == 0);
            PCSrcD       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            MemReqM      = ($urandom_range(0, 2) == 0);
            MemReadyM    = ($urandom_range(0, 3) != 0);
            #4;
            model_eval(e, m);
            got = outs_now();
            total++;
            if ((got & m) !== (e & m)) begin
                bad++;
                $display("FAIL random[%0d] got=%b want=%b", i, got & m, e & m);
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_forwarding();
        test_data_stall();
        test_pc_redirect();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined ARM-subset datapath (F/D/E/M/W). It generates the stall, flush and forward-select controls consumed by the inter-stage registers and the E-stage operand muxes. It also tracks in-flight PC writes and memory-wait cycles, and raises a bus fault on memory timeout. State updates on posedge CLK; all control outputs settle before the negedge CLK, where the stage registers capture.

Parameters:
TIMEOUT, 16, max consecutive MemReadyM-low cycles before bus fault
PC_DEPTH, 3, cycles from D to W for a PC-writing instruction

Ports:
CLK  in  1  clock
RESET_N  in  1  synchronous active-low reset, sampled on posedge CLK
RA1D, RA2D  in  4  D-stage source registers
RA1E, RA2E  in  4  E-stage source registers
WA3E, WA3M, WA3W  in  4  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  register write enables per stage
MemtoRegE  in  1  E-stage instruction is a load
PCSrcD  in  1  D-stage instruction writes R15
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  M-stage load or store active
MemReadyM  in  1  data memory completes this cycle
ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  insert bubble into stage register
BusFault  out  1  memory timeout, sticky

Behaviour:
- States: RUN, MEMWAIT, FAULT. Registers: state, pc_cnt (PC_DEPTH range), to_cnt ($clog2(TIMEOUT+1) bits).
- Reset (RESET_N low at posedge): state=RUN, pc_cnt=0, to_cnt=0. While RESET_N is low, outputs are combinationally forced to: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00, BusFault=0.
- Forwarding (operand A shown; B identical):
  - 10 if RegWriteM && WA3M==RA1E && RA1E!=15.
  - else 01 if RegWriteW && WA3W==RA1E && RA1E!=15.
  - else 00.
  - M has priority over W.
- LdStall = MemtoRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D). Combinational, lasts one cycle, since the bubble clears E.
- PcPend = PCSrcD || pc_cnt!=0. pc_cnt loads PC_DEPTH-1 when PCSrcD && !StallD, decrements when nonzero && !StallM, and saturates at 0.
- RUN outputs:
  - StallF = LdStall|PcPend
  - StallD = LdStall
  - FlushD = PcPend|BranchTakenE
  - FlushE = LdStall|BranchTakenE
  - StallE = StallM = FlushW = 0
- RUN->MEMWAIT when MemReqM && !MemReadyM; to_cnt=1.
- MEMWAIT outputs: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. LdStall and branch are ignored because the pipe is frozen.
- MEMWAIT transitions:
  - MemReadyM=1: go to RUN, to_cnt=0. The next cycle M advances.
  - else if to_cnt==TIMEOUT: go to FAULT.
  - else to_cnt increments.
- FAULT: BusFault=1 and all stalls=1, held until reset.
- Simultaneous events:
  - Memory wait dominates everything.
  - A taken branch in the same cycle as LdStall: FlushE=1 and FlushD=1. StallD is still asserted; flush takes priority in the stage register.
  - RESET_N low mid-MEMWAIT or mid-FAULT returns to RUN at the next posedge.
- Output latency: stalls and flushes are combinational in the same cycle as the hazard; state effects appear one posedge later.

Optional Feature:
HAZ_FWD_EN
- Defined: forwarding as specified above.
- Undefined: ForwardAE=ForwardBE=00 constant. RawStall replaces LdStall: RawStall = any of (RegWriteE,WA3E), (RegWriteM,WA3M), (RegWriteW,WA3W) matching RA1D or RA2D (excluding R15). RawStall drives StallF, StallD and FlushE identically to LdStall.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEMWAIT, FAULT}
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - REG_PC=4'd15
- Sub-module fwd_sel: a per-operand M/W comparator with priority encode, instantiated for A and B.

Test Plan:
- ADD R1 in M (RegWriteM, WA3M=1), RA1E=1, W also writing R1 -> ForwardAE=10.
- RA2E=15, RegWriteM with WA3M=15 -> ForwardBE=00.
- LDR R2 in E (MemtoRegE, WA3E=2), RA1D=2 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then all 0.
- PCSrcD=1 with no mem stall -> StallF=FlushD=1 for 3 cycles (PC_DEPTH). Repeat with MemReadyM held low 2 cycles midway -> window stretches to 5 cycles.
- MemReqM=1, MemReadyM low for 4 cycles then high -> StallF..M=1 and FlushW=1 for 4 cycles; RUN on the 5th cycle; BusFault=0.
- MemReadyM held low for 17 cycles -> BusFault=1 and stays high. Pulse RESET_N low one posedge -> BusFault=0, state RUN, FlushD/E/W=1 during reset.
